// File: rtl/dmem_sized_if.sv
// Request/response bundle between the MEM stage and the data memory,
// plus the debug word-view lines.
interface dmem_sized_if #(
    parameter int DEPTH_WORDS = 64
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   address;
    logic [31:0]   write_data;
    logic          memorywrite;
    logic          memoryread;
    logic [2:0]    funct3;
    logic [31:0]   read_data;
    logic          read_valid;
    logic          fault;
    logic          busy;
    logic [AW-1:0] view_index;
    logic [31:0]   view_data;

    modport master (
        output address, write_data, memorywrite, memoryread, funct3, view_index,
        input  read_data, read_valid, fault, busy, view_data
    );

    modport slave (
        input  address, write_data, memorywrite, memoryread, funct3, view_index,
        output read_data, read_valid, fault, busy, view_data
    );
endinterface

// File: rtl/dmem_sized.sv
// Byte-addressed data memory for the RV32 MEM stage: sized stores with byte
// enables, sign/zero-extended loads with one-cycle latency, fault detection,
// and a zeroing sweep after every reset.
module dmem_sized #(
    parameter  int DEPTH_WORDS = 64,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input logic         clk,
    input logic         reset_n,
    dmem_sized_if.slave bus
);
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] clr_cnt_reg;
    logic [31:0]   read_data_reg;
    logic          read_valid_reg;
    logic          fault_reg;

    logic          busy, clearing, accept;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic          in_range, misaligned, ld_f3_ok, st_f3_ok;
    logic          ld_fault, st_fault, do_write;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lanes;
    logic [31:0]   rd_word, view_word;
    logic [31:0]   shifted, load_value;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    assign word_idx = bus.address[AW+1:2];
    assign byte_off = bus.address[1:0];

    // State register: every reset restarts the zeroing sweep
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_CLEAR;
        else          state_reg <= state_next;
    end

    // Next state: leave CLEAR once the last word has been zeroed
    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_CLEAR && clr_cnt_reg == AW'(DEPTH_WORDS - 1))
            state_next = ST_RUN;
    end

    // State outputs: busy while sweeping, requests served only in RUN
    always_comb begin
        busy     = (state_reg == ST_CLEAR);
        clearing = (state_reg == ST_CLEAR);
        accept   = (state_reg == ST_RUN);
    end

    // Sweep word counter, one word per cycle while clearing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      clr_cnt_reg <= '0;
        else if (clearing) clr_cnt_reg <= clr_cnt_reg + AW'(1);
    end

    // Request decode: range, alignment and funct3 legality for each access kind
    always_comb begin
        in_range = (bus.address >> (AW + 2)) == 32'd0;
        case (bus.funct3[1:0])
            2'b01:   misaligned = byte_off[0];
            2'b10:   misaligned = (byte_off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        ld_f3_ok = (bus.funct3[1:0] != 2'b11) && (bus.funct3[2:1] != 2'b11);
        st_f3_ok = !bus.funct3[2] && (bus.funct3[1:0] != 2'b11);
        ld_fault = bus.memoryread  && !(ld_f3_ok && in_range && !misaligned);
        st_fault = bus.memorywrite && !(st_f3_ok && in_range && !misaligned);
        do_write = accept && bus.memorywrite && !st_fault;
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        case (bus.funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << byte_off;
                wdata_lanes = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                byte_en     = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{bus.write_data[15:0]}};
            end
            default: begin
                byte_en     = 4'b1111;
                wdata_lanes = bus.write_data;
            end
        endcase
    end

    // One byte-wide array per lane so each lane has its own write enable
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];

        // Sweep zeroing takes priority; otherwise write this lane if enabled
        always_ff @(posedge clk) begin
            if (clearing)
                lane_mem[clr_cnt_reg] <= 8'h00;
            else if (do_write && byte_en[gi])
                lane_mem[word_idx] <= wdata_lanes[8*gi +: 8];
        end

        assign rd_word[8*gi +: 8]   = lane_mem[word_idx];
        assign view_word[8*gi +: 8] = lane_mem[bus.view_index];
    end

    // Load lane selection and sign/zero extension of the pre-write word
    always_comb begin
        shifted  = rd_word >> {byte_off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.funct3)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_value = {24'h0, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_value = {16'h0, half_sel};
            default: load_value = rd_word;
        endcase
    end

    // Registered load response and fault pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_reg  <= 32'h0;
            read_valid_reg <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            read_valid_reg <= accept && bus.memoryread;
            fault_reg      <= accept && (ld_fault || st_fault);
            if (accept && bus.memoryread)
                read_data_reg <= ld_fault ? 32'h0 : load_value;
        end
    end

    assign bus.read_data  = read_data_reg;
    assign bus.read_valid = read_valid_reg;
    assign bus.fault      = fault_reg;
    assign bus.busy       = busy;
    assign bus.view_data  = view_word;
endmodule
